// File: rtl/tpu_pkg.sv
// Shared defaults and state encoding for the TPU operand feeders.
package tpu_pkg;

    localparam int DEF_DIM     = 8;
    localparam int DEF_BITS_AB = 8;
    localparam int STREAM_LEN  = 2 * DEF_DIM - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feed_state_t;

endpackage

// File: rtl/tpu_tile_buf.sv
// DIM x DIM operand tile: one synchronous row-write port, full tile read combinationally.
module tpu_tile_buf import tpu_pkg::*; #(
    parameter int BITS_AB = DEF_BITS_AB,
    parameter int DIM     = DEF_DIM,
    parameter int AW      = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we,
    input  logic [AW-1:0]                        waddr,
    input  logic [DIM-1:0][BITS_AB-1:0]          wdata,
    output logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] tile
);

    // Caller guarantees waddr < DIM whenever we is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile <= '0;
        end else if (we) begin
            tile[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/tpu_skew_feeder.sv
// Streams a buffered A tile into the systolic array with lane r delayed r cycles.
module tpu_skew_feeder import tpu_pkg::*; #(
    parameter int BITS_AB = DEF_BITS_AB,
    parameter int DIM     = DEF_DIM
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_en,
    input  logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] wr_row,
    input  logic [DIM*BITS_AB-1:0]                   wr_data,
    input  logic                                     start,
    output logic                                     busy,
    output logic [DIM*BITS_AB-1:0]                   a_out,
    output logic                                     a_valid,
    output logic                                     done
);

    localparam int AW  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int KW  = $clog2(2 * DIM);
    localparam int LEN = 2 * DIM - 1;

    feed_state_t                          state;
    logic [KW-1:0]                        k;
    logic [KW-1:0]                        step;
    logic                                 wr_acc;
    logic [DIM-1:0][BITS_AB-1:0]          wrow;
    logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] tile;
    logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] rows;
    logic [DIM-1:0][BITS_AB-1:0]          lanes;

    assign wrow   = wr_data;
    assign wr_acc = wr_en && (state != STREAM) && (int'(wr_row) < DIM);

    tpu_tile_buf #(.BITS_AB(BITS_AB), .DIM(DIM), .AW(AW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_row),
        .wdata (wrow),
        .tile  (tile)
    );

    // k holds the next step to emit; a stream launch always emits step 0.
    assign step = (state == STREAM) ? k : '0;

    for (genvar r = 0; r < DIM; r++) begin : g_lane
        logic [KW-1:0] diff;
        logic          in_win;
        // Bypass lets a same-edge write feed the step-0 launch.
        assign rows[r] = (wr_acc && wr_row == AW'(r)) ? wrow : tile[r];
        assign diff    = step - KW'(r);
        assign in_win  = (step >= KW'(r)) && (diff < KW'(DIM));
        assign lanes[r] = in_win ? rows[r][AW'(diff)] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            a_out   <= '0;
            a_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= STREAM;
                        k       <= KW'(1);
                        a_out   <= lanes;
                        a_valid <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                STREAM: begin
                    if (k == KW'(LEN)) begin
                        state   <= DONE;
                        k       <= '0;
                        a_out   <= '0;
                        a_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        k     <= k + KW'(1);
                        a_out <= lanes;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// Directed checks of the skewed tile feeder at DIM=4.
module tb_tpu_skew_feeder;

    localparam int B = 8;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst, wr_en, start;
    logic [1:0]  wr_row;
    logic [31:0] wr_data;
    logic        busy, a_valid, done;
    logic [31:0] a_out;

    int n_tests = 0;
    int n_fail  = 0;

    tpu_skew_feeder #(.BITS_AB(B), .DIM(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .a_out   (a_out),
        .a_valid (a_valid),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  row;
        logic [31:0] data;
        logic        st;
        logic [31:0] ea;
        logic        ev;
        logic        eb;
        logic        ed;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] p4(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic vec_t mk(int r, int we, int row, logic [31:0] data, int st,
                                logic [31:0] ea, int ev, int eb, int ed);
        vec_t v;
        v.rst = (r != 0);   v.we = (we != 0); v.row = 2'(row); v.data = data;
        v.st  = (st != 0);  v.ea = ea;        v.ev = (ev != 0);
        v.eb  = (eb != 0);  v.ed = (ed != 0);
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(string nm, logic [31:0] ea, logic ev, logic eb, logic ed);
        chk({nm, ".a_out"}, a_out, ea);
        chk({nm, ".a_valid"}, {31'b0, a_valid}, {31'b0, ev});
        chk({nm, ".busy"}, {31'b0, busy}, {31'b0, eb});
        chk({nm, ".done"}, {31'b0, done}, {31'b0, ed});
    endtask

    task automatic cyc(logic r, logic we, logic [1:0] row, logic [31:0] data, logic st);
        rst = r; wr_en = we; wr_row = row; wr_data = data; start = st;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, ".done_seen"}, {31'b0, got}, 32'h1);
    endtask

    logic [31:0] ka[7];
    logic [31:0] kn[7];

    initial begin
        int nv, bad;
        logic seen;

        rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;

        // Stream content of the 10*r+c+1 tile, step 0..6
        ka = '{p4(1, 0, 0, 0), p4(2, 11, 0, 0), p4(3, 12, 21, 0), p4(4, 13, 22, 31),
               p4(0, 14, 23, 32), p4(0, 0, 24, 33), p4(0, 0, 0, 34)};
        kn = ka;
        kn[0] = 32'h0000_0080;

        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int r = 0; r < D; r++)
            vt.push_back(mk(0, 1, r, p4(10*r+1, 10*r+2, 10*r+3, 10*r+4), 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, ka[0], 1, 1, 0));
        for (int k = 1; k < 7; k++)
            vt.push_back(mk(0, 0, 0, 0, 0, ka[k], 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Second stream: row-2 write of 0x55 while streaming must be dropped
        vt.push_back(mk(0, 0, 0, 0, 1, ka[0], 1, 1, 0));
        vt.push_back(mk(0, 1, 2, 32'h5555_5555, 0, ka[1], 1, 1, 0));
        for (int k = 2; k < 7; k++)
            vt.push_back(mk(0, 0, 0, 0, 0, ka[k], 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Restart from DONE; the next stream still carries old row 2
        vt.push_back(mk(0, 0, 0, 0, 1, ka[0], 1, 1, 0));
        for (int k = 1; k < 7; k++)
            vt.push_back(mk(0, 0, 0, 0, 0, ka[k], 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].we, vt[i].row, vt[i].data, vt[i].st);
            chk_out($sformatf("vec%0d", i), vt[i].ea, vt[i].ev, vt[i].eb, vt[i].ed);
        end

        // -128 in A[0][0] passes through bit-exact
        cyc(1'b0, 1'b1, 2'd0, p4(-128, 2, 3, 4), 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        chk_out("neg_k0", 32'h0000_0080, 1'b1, 1'b1, 1'b0);
        wait_done("neg");
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);

        // start held high across two tiles
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        chk_out("hold_k0", kn[0], 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 7; k++) begin
            cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
            chk_out($sformatf("hold_k%0d", k), kn[k], 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        chk_out("hold_done", 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        chk_out("hold_k0_b", kn[0], 1'b1, 1'b1, 1'b0);
        wait_done("hold2");
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        chk_out("hold_idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset at k=3 aborts with no done; tile is cleared
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        for (int k = 1; k < 4; k++) cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        chk_out("pre_rst_k3", kn[3], 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
        chk_out("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        chk_out("rst_after", 32'h0, 1'b0, 1'b0, 1'b0);

        nv = 0; bad = 0; seen = 1'b0;
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (a_valid) nv++;
            if (a_out != 32'h0) bad++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        end
        chk("zero_tile.valid_cycles", nv, 32'd7);
        chk("zero_tile.nonzero", bad, 32'd0);
        chk("zero_tile.done_seen", {31'b0, seen}, 32'h1);

        // Same-edge write and start
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, p4(7, 7, 7, 7), 1'b1);
        chk_out("bypass_k0", p4(7, 0, 0, 0), 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("bypass_k1", a_out, p4(7, 0, 0, 0));
        wait_done("bypass");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
